// File: rtl/arb_pkg.sv
// Shared types for the four-way round-robin scheduler: requester count,
// owner index, FSM states and the index-to-grant decoder.
package arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] owner_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot4(input owner_idx_t idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating priority search: first set request bit found
// scanning start, start+1, ... modulo 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  owner_idx_t       start,
    output logic             found,
    output owner_idx_t       idx
);

    owner_idx_t cand_s;

    // Walk the four positions from start; the first hit wins.
    always_comb begin
        found  = 1'b0;
        idx    = start;
        cand_s = start;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = start + 2'(k);
            if (!found && req[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/arb4_rr_sched.sv
// Round-robin owner selection for a shared 4:1 mux with capped bursts;
// the owner index drives the mux selects directly.
module arb4_rr_sched
    import arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             last,
    output logic [N_REQ-1:0] grant,
    output logic             sel0,
    output logic             sel1,
    output logic             busy
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t           state_r, state_n;
    owner_idx_t       ptr_r, ptr_n;
    logic [3:0]       cnt_r, cnt_n;
    owner_idx_t       sel_r, sel_n;
    logic [N_REQ-1:0] grant_n;
    logic             busy_n;

    owner_idx_t       owner_s;
    owner_idx_t       start_s;
    owner_idx_t       pick_s;
    logic             found_s;
    logic             release_s;

    assign owner_s = sel_r;
    assign sel0    = sel_r[0];
    assign sel1    = sel_r[1];

    // While owning, the search starts just past the owner so the owner
    // itself is reached last and only re-granted when nobody else asks.
    assign start_s   = (state_r == OWN) ? owner_s + 2'd1 : ptr_r;
    assign release_s = !req[owner_s] || last || (cnt_r == MAX_CNT);

    rr_pick4 u_pick (
        .req   (req),
        .start (start_s),
        .found (found_s),
        .idx   (pick_s)
    );

    // Next-state decode: acquire from idle, hold, hand over or go idle.
    always_comb begin
        state_n = state_r;
        ptr_n   = ptr_r;
        cnt_n   = cnt_r;
        sel_n   = sel_r;
        grant_n = grant;
        busy_n  = busy;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_n = OWN;
                    grant_n = onehot4(pick_s);
                    sel_n   = pick_s;
                    busy_n  = 1'b1;
                    cnt_n   = 4'd1;
                end else begin
                    grant_n = 4'b0000;
                    busy_n  = 1'b0;
                end
            end
            OWN: begin
                if (release_s) begin
                    ptr_n = owner_s + 2'd1;
                    if (found_s) begin
                        grant_n = onehot4(pick_s);
                        sel_n   = pick_s;
                        busy_n  = 1'b1;
                        cnt_n   = 4'd1;
                    end else begin
                        state_n = IDLE;
                        grant_n = 4'b0000;
                        busy_n  = 1'b0;
                    end
                end else if (cnt_r != MAX_CNT) begin
                    cnt_n = cnt_r + 4'd1;
                end else begin
                    cnt_n = cnt_r;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 4'b0000;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; sel keeps the last owner while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            ptr_r   <= 2'd0;
            cnt_r   <= 4'd0;
            sel_r   <= 2'd0;
            grant   <= 4'b0000;
            busy    <= 1'b0;
        end else begin
            state_r <= state_n;
            ptr_r   <= ptr_n;
            cnt_r   <= cnt_n;
            sel_r   <= sel_n;
            grant   <= grant_n;
            busy    <= busy_n;
        end
    end

endmodule

// File: tb/tb_arb4_rr_sched.sv
// Directed plus randomized stimulus for arb4_rr_sched, checked cycle by cycle
// against an owner/count/pointer model of the round-robin rules.
module tb_arb4_rr_sched;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic       last;
    logic [3:0] grant;
    logic       sel0, sel1, busy;

    int errors = 0;
    int checks = 0;

    // model state: who owns, beats so far, round-robin start, last owner
    int m_own, m_cnt, m_ptr, m_sel;
    bit m_busy;

    arb4_rr_sched #(.MAX_BURST(MB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .last    (last),
        .grant   (grant),
        .sel0    (sel0),
        .sel1    (sel1),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_own = 0; m_cnt = 0; m_ptr = 0; m_sel = 0; m_busy = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic l);
        int nxt;
        nxt = -1;
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (nxt < 0 && r[j]) nxt = j;
            end
        end else begin
            if (r[m_own] && !l && m_cnt < MB) begin
                m_cnt = m_cnt + 1;
                return;
            end
            m_ptr = (m_own + 1) % 4;
            for (int k = 1; k <= 4; k++) begin
                int j;
                j = (m_own + k) % 4;
                if (nxt < 0 && r[j]) nxt = j;
            end
        end
        if (nxt >= 0) begin
            m_busy = 1'b1; m_own = nxt; m_sel = nxt; m_cnt = 1;
        end else begin
            m_busy = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag);
        logic [3:0] eg;
        logic [1:0] es;
        eg = m_busy ? (4'b0001 << m_own) : 4'b0000;
        es = 2'(m_sel);
        check({tag, ".grant"}, grant, eg);
        check({tag, ".sel"}, {2'b00, sel1, sel0}, {2'b00, es});
        check({tag, ".busy"}, {3'b000, busy}, {3'b000, m_busy});
    endtask

    task automatic step(input logic [3:0] r, input logic l, input string tag);
        req  = r;
        last = l;
        @(posedge clk);
        model_edge(r, l);
        #1;
        check_outs(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 4'b1111;
        last    = 1'b0;
        model_reset();

        // reset held with all requests pending
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset_hold");
        reset_n = 1'b1;
        step(4'b1111, 1'b0, "reset_release");
        check("first_grant", grant, 4'b0001);

        // single long request: cap then direct re-grant
        do_reset();
        for (int i = 0; i < 10; i++) step(4'b0100, 1'b0, "long_req");

        // fair rotation with all requesting
        do_reset();
        for (int i = 0; i < 20; i++) step(4'b1111, 1'b0, "rotation");

        // last handoff from owner 1 to requester 0 by wrap-around
        do_reset();
        step(4'b0010, 1'b0, "own1_acquire");
        step(4'b0011, 1'b0, "own1_beat2");
        step(4'b0011, 1'b1, "own1_last");
        check("last_handoff", grant, 4'b0001);
        step(4'b0001, 1'b0, "own0_hold");

        // owner 2 drops its request, then requester 3 arrives
        do_reset();
        step(4'b0100, 1'b0, "own2_acquire");
        step(4'b0100, 1'b0, "own2_hold");
        step(4'b0000, 1'b0, "own2_drop");
        check("drop_sel", {2'b00, sel1, sel0}, 4'b0010);
        step(4'b1000, 1'b0, "req3_arrive");
        check("req3_grant", grant, 4'b1000);

        // asynchronous reset between edges while requester 3 owns
        req = 4'b1000;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outs("async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(4'b1111, 1'b0, "after_async");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            logic       l;
            r = 4'($urandom_range(0, 15));
            l = ($urandom_range(0, 3) == 0);
            step(r, l, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
